// File: rtl/sha_block_feeder.sv
// sha_block_feeder: byte-stream front end for SHA-256 message expansion.
// Packs bytes big-endian into a 16-word block, applies SHA-256 padding
// (0x80 marker, zero fill, 64-bit bit length) and streams each block to
// the expander as 16 indexed words. It then waits for the expander's
// done pulse before starting the next block.
module sha_block_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 61
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  input  logic                  byte_last_in,
  output logic                  byte_ready_out,
  input  logic                  me_done_in,
  output logic                  start_out,
  output logic [4:0]            tx_count_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  block_last_out,
  output logic                  msg_done_out,
  output logic                  busy_out
);

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_PAD  = 3'd1,
    S_LEN  = 3'd2,
    S_SEND = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   blk_buf [16];
  logic [5:0]              byte_ptr;
  logic [LEN_WIDTH-1:0]    byte_count;
  logic                    final_r;
  logic                    mark_pending_r;
  logic                    len_owed_r;     // marker sent, length goes in an extra block
  logic [3:0]              tx_idx;
  logic [63:0]             bitlen;
  logic                    byte_fire;
  logic                    done_ok;

  assign bitlen    = 64'(byte_count) << 3;
  assign byte_fire = (state == S_FILL) && byte_valid_in;
  // The last word of a burst is still on the outputs during the first
  // S_WAIT cycle; a done pulse is only honoured once the burst has ended.
  assign done_ok   = (state == S_WAIT) && me_done_in && !start_out;

  assign byte_ready_out = (state == S_FILL);
  assign busy_out       = !((state == S_FILL) && (byte_ptr == 6'd0) && (byte_count == '0));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      S_FILL: begin
        if (byte_fire) begin
          if (byte_last_in) begin
            state_next = (byte_ptr == 6'd63) ? S_SEND : S_PAD;
          end else if (byte_ptr == 6'd63) begin
            state_next = S_SEND;
          end
        end
      end
      S_PAD:  state_next = (byte_ptr <= 6'd55) ? S_LEN : S_SEND;
      S_LEN:  state_next = S_SEND;
      S_SEND: begin
        if (tx_idx == 4'd15) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_ok) begin
          if (mark_pending_r) begin
            state_next = S_PAD;
          end else if (len_owed_r) begin
            state_next = S_LEN;
          end else begin
            state_next = S_FILL;
          end
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  // Block buffer, counters, flags and registered expander outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        blk_buf[i] <= '0;
      end
      byte_ptr       <= '0;
      byte_count     <= '0;
      final_r        <= 1'b0;
      mark_pending_r <= 1'b0;
      len_owed_r     <= 1'b0;
      tx_idx         <= '0;
      start_out      <= 1'b0;
      tx_count_out   <= '0;
      data_out       <= '0;
      block_last_out <= 1'b0;
      msg_done_out   <= 1'b0;
    end else begin
      start_out      <= 1'b0;
      tx_count_out   <= '0;
      data_out       <= '0;
      block_last_out <= 1'b0;
      msg_done_out   <= 1'b0;
      case (state)
        S_FILL: begin
          if (byte_fire) begin
            blk_buf[byte_ptr[5:2]][{~byte_ptr[1:0], 3'b000} +: 8] <= byte_in;
            byte_ptr   <= byte_ptr + 6'd1;
            byte_count <= byte_count + LEN_WIDTH'(1);
            if (byte_last_in && (byte_ptr == 6'd63)) begin
              mark_pending_r <= 1'b1;
            end
            if (byte_last_in || (byte_ptr == 6'd63)) begin
              final_r <= 1'b0;
            end
          end
        end
        S_PAD: begin
          blk_buf[byte_ptr[5:2]][{~byte_ptr[1:0], 3'b000} +: 8] <= 8'h80;
          if (byte_ptr > 6'd55) begin
            final_r    <= 1'b0;
            len_owed_r <= 1'b1;
          end
        end
        S_LEN: begin
          blk_buf[14] <= bitlen[63:32];
          blk_buf[15] <= bitlen[31:0];
          final_r     <= 1'b1;
          len_owed_r  <= 1'b0;
        end
        S_SEND: begin
          start_out      <= 1'b1;
          tx_count_out   <= {1'b0, tx_idx};
          data_out       <= blk_buf[tx_idx];
          block_last_out <= final_r;
          tx_idx         <= tx_idx + 4'd1;
        end
        S_WAIT: begin
          if (done_ok) begin
            // Clearing here provides the zero fill for the next block.
            for (int i = 0; i < 16; i++) begin
              blk_buf[i] <= '0;
            end
            byte_ptr <= '0;
            tx_idx   <= '0;
            if (mark_pending_r) begin
              mark_pending_r <= 1'b0;
            end else if (!len_owed_r && final_r) begin
              msg_done_out <= 1'b1;
              byte_count   <= '0;
              final_r      <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_block_feeder.sv
// Testbench for sha_block_feeder: a padding model builds the expected
// word stream from each message; a monitor compares every burst word and
// an expander stand-in answers each block with a done pulse.
module tb_sha_block_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_last_in;
  logic        byte_ready_out;
  logic        me_done_in = 1'b0;
  logic        start_out;
  logic [4:0]  tx_count_out;
  logic [31:0] data_out;
  logic        block_last_out;
  logic        msg_done_out;
  logic        busy_out;

  int errors = 0;
  int checks = 0;

  logic [7:0]  msg_q[$];
  logic [31:0] exp_word[$];
  logic [4:0]  exp_idx[$];
  logic        exp_last[$];
  logic [31:0] cap_word[$];
  logic        cap_last[$];

  bit hold_done = 0;
  bit inject_req = 0;
  bit outstanding = 0;
  bit out_final = 0;
  bit done_acked = 0;
  bit start_prev = 0;
  bit last_seen_final = 0;
  int delay = 0;
  int md_count = 0;

  always #5 clk = ~clk;

  sha_block_feeder #(.DATA_WIDTH(32), .LEN_WIDTH(61)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .byte_last_in(byte_last_in), .byte_ready_out(byte_ready_out), .me_done_in(me_done_in),
    .start_out(start_out), .tx_count_out(tx_count_out), .data_out(data_out),
    .block_last_out(block_last_out), .msg_done_out(msg_done_out), .busy_out(busy_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: pad the whole message, cut into 64-byte blocks, words big-endian.
  task automatic model_msg();
    logic [7:0]  p[$];
    logic [63:0] bl;
    int          nblk;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(msg_q.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 16; w++) begin
        exp_word.push_back({p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]});
        exp_idx.push_back(5'(w));
        exp_last.push_back(b == nblk - 1);
      end
    end
  endtask

  task automatic send_msg(input bit gaps);
    int tmo;
    for (int i = 0; i < msg_q.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        byte_valid_in = 1'b0;
        byte_in = 8'($urandom);
        @(negedge clk);
      end
      byte_in = msg_q[i];
      byte_valid_in = 1'b1;
      byte_last_in = (i == msg_q.size() - 1);
      tmo = 0;
      while (!byte_ready_out && tmo < 3000) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 3000) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d never accepted (ready=%0b, required 1)", i, byte_ready_out);
        break;
      end
      @(negedge clk);
    end
    byte_valid_in = 1'b0;
    byte_last_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int tmo = 0;
    while (!(exp_word.size() == 0 && !outstanding && !busy_out && !me_done_in) && tmo < 5000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 5000) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout: pending words %0d, busy %0b (required 0 and 0)", name, exp_word.size(), busy_out);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_cap(input string name, input int pos, input logic [31:0] w, input logic l);
    if (pos >= cap_word.size()) begin
      checks++; errors++;
      $display("FAIL %s: word %0d missing (captured %0d, required %0h)", name, pos, cap_word.size(), w);
    end else begin
      chk(name, {31'd0, cap_last[pos], cap_word[pos]}, {31'd0, l, w});
    end
  endtask

  task automatic run_msg(input string name, input bit gaps);
    int md0 = md_count;
    model_msg();
    send_msg(gaps);
    wait_idle(name);
    chk({name, "_msg_done_cnt"}, 64'(md_count - md0), 64'd1);
    $display("msg %s: %0d bytes, checks so far %0d", name, msg_q.size(), checks);
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
  endtask

  task automatic load_fill(input int n, input logic [7:0] v);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(v);
  endtask

  // Word monitor: every burst word against the model's next expected word.
  always @(negedge clk) begin
    if (rst_n && start_out) begin
      chk("ready_during_burst", 64'(byte_ready_out), 64'd0);
      cap_word.push_back(data_out);
      cap_last.push_back(block_last_out);
      last_seen_final = block_last_out;
      if (exp_word.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: idx %0d data %0h, required no transfer", tx_count_out, data_out);
      end else begin
        chk("word", {26'd0, tx_count_out, block_last_out, data_out},
            {26'd0, exp_idx[0], exp_last[0], exp_word[0]});
        void'(exp_word.pop_front());
        void'(exp_idx.pop_front());
        void'(exp_last.pop_front());
      end
    end
  end

  // Expander stand-in: acknowledges each finished burst and checks msg_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      me_done_in = 1'b0;
      outstanding = 0;
      done_acked = 0;
      start_prev = 0;
      inject_req = 0;
    end else begin
      chk("msg_done", 64'(msg_done_out), 64'(done_acked));
      if (msg_done_out) md_count++;
      done_acked = 0;
      me_done_in = 1'b0;
      if (start_prev && !start_out) begin
        outstanding = 1;
        out_final = last_seen_final;
        delay = $urandom_range(0, 4);
      end
      if (inject_req) begin
        me_done_in = 1'b1;
        inject_req = 0;
      end else if (outstanding && !hold_done) begin
        if (delay == 0) begin
          me_done_in = 1'b1;
          outstanding = 0;
          done_acked = out_final;
        end else begin
          delay--;
        end
      end
      start_prev = start_out;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int tmo;
    int bad_ready;
    int bad_start;
    int lens[8] = '{1, 55, 56, 63, 64, 119, 120, 128};

    rst_n = 1'b0;
    byte_in = 8'h00;
    byte_valid_in = 1'b0;
    byte_last_in = 1'b0;
    #1;
    chk("rst_start", 64'(start_out), 64'd0);
    chk("rst_tx_count", 64'(tx_count_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_block_last", 64'(block_last_out), 64'd0);
    chk("rst_msg_done", 64'(msg_done_out), 64'd0);
    chk("rst_ready", 64'(byte_ready_out), 64'd1);
    chk("rst_busy", 64'(busy_out), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" with a done pulse injected mid-burst (must be ignored).
    load_abc();
    base = cap_word.size();
    model_msg();
    fork
      send_msg(1'b0);
      begin
        tmo = 0;
        while (!(start_out && tx_count_out == 5'd4) && tmo < 200) begin
          @(negedge clk);
          tmo++;
        end
        inject_req = 1;
      end
    join
    wait_idle("abc");
    chk("abc_burst_words", 64'(cap_word.size() - base), 64'd16);
    chk_cap("abc_w0", base, 32'h61626380, 1'b1);
    chk_cap("abc_w1", base + 1, 32'h0, 1'b1);
    chk_cap("abc_w15", base + 15, 32'h00000018, 1'b1);
    chk("abc_md_count", 64'(md_count), 64'd1);

    load_fill(55, 8'h00);
    base = cap_word.size();
    run_msg("z55", 1'b0);
    chk_cap("z55_w13", base + 13, 32'h00000080, 1'b1);
    chk_cap("z55_w14", base + 14, 32'h0, 1'b1);
    chk_cap("z55_w15", base + 15, 32'h000001B8, 1'b1);

    load_fill(56, 8'h00);
    base = cap_word.size();
    run_msg("z56", 1'b1);
    chk_cap("z56_b1_w14", base + 14, 32'h80000000, 1'b0);
    chk_cap("z56_b1_w15", base + 15, 32'h0, 1'b0);
    chk_cap("z56_b2_w14", base + 30, 32'h0, 1'b1);
    chk_cap("z56_b2_w15", base + 31, 32'h000001C0, 1'b1);

    // 64 x 0xFF with the done pulse withheld for 100 cycles after block 1.
    load_fill(64, 8'hFF);
    base = cap_word.size();
    hold_done = 1;
    model_msg();
    send_msg(1'b0);
    tmo = 0;
    while (!outstanding && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    chk("hold_block1_seen", 64'(outstanding), 64'd1);
    bad_ready = 0;
    bad_start = 0;
    repeat (100) begin
      @(negedge clk);
      if (byte_ready_out) bad_ready++;
      if (start_out) bad_start++;
    end
    chk("hold_ready_low", 64'(bad_ready), 64'd0);
    chk("hold_no_burst", 64'(bad_start), 64'd0);
    chk("hold_busy", 64'(busy_out), 64'd1);
    hold_done = 0;
    wait_idle("ff64");
    chk_cap("ff64_b1_w0", base, 32'hFFFFFFFF, 1'b0);
    chk_cap("ff64_b1_w15", base + 15, 32'hFFFFFFFF, 1'b0);
    chk_cap("ff64_b2_w0", base + 16, 32'h80000000, 1'b1);
    chk_cap("ff64_b2_w15", base + 31, 32'h00000200, 1'b1);

    // Random messages: boundary lengths first, then random lengths.
    for (int m = 0; m < 18; m++) begin
      int n;
      n = (m < 8) ? lens[m] : $urandom_range(1, 150);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d", m), 1'b1);
    end

    // Reset in the middle of a burst.
    msg_q.delete();
    for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
    model_msg();
    send_msg(1'b1);
    tmo = 0;
    while (!(start_out && tx_count_out == 5'd7) && tmo < 300) begin
      @(negedge clk);
      tmo++;
    end
    chk("abort_reached_idx7", 64'(tx_count_out), 64'd7);
    rst_n = 1'b0;
    #1;
    chk("abort_start", 64'(start_out), 64'd0);
    chk("abort_tx_count", 64'(tx_count_out), 64'd0);
    chk("abort_data", 64'(data_out), 64'd0);
    chk("abort_block_last", 64'(block_last_out), 64'd0);
    chk("abort_msg_done", 64'(msg_done_out), 64'd0);
    exp_word.delete();
    exp_idx.delete();
    exp_last.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 64'(byte_ready_out), 64'd1);
    chk("abort_busy_after", 64'(busy_out), 64'd0);
    repeat (30) @(negedge clk);
    load_abc();
    base = cap_word.size();
    run_msg("abc_again", 1'b0);
    chk_cap("abc2_w0", base, 32'h61626380, 1'b1);
    chk_cap("abc2_w15", base + 15, 32'h00000018, 1'b1);

    chk("leftover_words", 64'(exp_word.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha_block_feeder.md
Name: sha_block_feeder

Overview:
Byte-stream front end for the SHA-256 message expansion. Accepts message bytes over a valid/ready handshake and packs them big-endian into a 16-word block buffer. Applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit-length) and streams each 512-bit block to the expander as 16 indexed words. Holds off the next block until the expander signals completion.

Parameters:
DATA_WIDTH, 32, word width toward the expander; only 32 is supported.
LEN_WIDTH, 61, byte-counter width; bit length = {byte_count, 3'b000}, zero-extended to 64 bits.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
byte_in  input  8  message byte
byte_valid_in  input  1  byte_in is valid
byte_last_in  input  1  qualifies byte_in as the final message byte (only meaningful with byte_valid_in)
byte_ready_out  output  1  feeder can accept a byte this cycle
me_done_in  input  1  single-cycle pulse from the expander: block processed
start_out  output  1  word-transfer strobe to the expander
tx_count_out  output  5  word index 0..15 of data_out
data_out  output  DATA_WIDTH  block word
block_last_out  output  1  current block is the final (length-carrying) block
msg_done_out  output  1  one-cycle pulse: final block acknowledged
busy_out  output  1  high in every state except S_FILL with byte_ptr==0 and no message in progress

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk): state S_FILL; buffer words, byte_ptr, byte_count and flags cleared.
- Reset values of outputs: start_out=0, tx_count_out=0, data_out=0, block_last_out=0, msg_done_out=0, byte_ready_out=1 (combinational).
- Reset asserted mid-operation aborts the message. No partial block is sent after release.
- Storage: buf[0:15] x 32 bits; byte_ptr 6 bits; byte_count LEN_WIDTH bits; flags final_r and mark_pending_r.
- States: S_FILL, S_PAD, S_LEN, S_SEND, S_WAIT (3-bit encoding).
- S_FILL:
  - byte_ready_out=1.
  - On handshake, byte goes to buf[byte_ptr[5:2]] bits [31-8*byte_ptr[1:0] -: 8]; byte_ptr+1; byte_count+1.
  - Full block (byte_ptr==63) without last: go S_SEND, final_r=0.
  - Last with byte_ptr<63: go S_PAD.
  - Last with byte_ptr==63: set mark_pending_r, go S_SEND with final_r=0.
- S_PAD (1 cycle):
  - Write 0x80 at byte_ptr.
  - If byte_ptr<=55, go S_LEN.
  - Else go S_SEND with final_r=0 and the length still owed.
- S_LEN (1 cycle): buf[14]=bitlen[63:32], buf[15]=bitlen[31:0]; final_r=1; go S_SEND.
- byte_ready_out=0 in S_PAD, S_LEN, S_SEND and S_WAIT.
- S_SEND:
  - Exactly 16 consecutive cycles with start_out=1, tx_count_out=0..15 ascending, data_out=buf[tx_count_out].
  - All outputs are registered.
  - block_last_out=final_r, held for all 16 cycles.
  - After index 15, start_out drops and the block goes to S_WAIT.
- S_WAIT:
  - On me_done_in: clear buf and byte_ptr.
  - If mark_pending_r: clear it and go S_PAD (the marker lands at byte 0).
  - Else if the length is still owed: go S_LEN.
  - Else if final_r: pulse msg_done_out, clear byte_count and final_r, go S_FILL.
  - Else (plain full block): go S_FILL.
- me_done_in outside S_WAIT is ignored.
- Zero fill needs no extra cycles because buf is cleared on entry to each new block.
- Minimum message is 1 byte. byte_count wraps modulo 2^LEN_WIDTH, with no error flag.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one block with block_last_out=1: w0=0x61626380, w1..w14=0, w15=0x00000018; then msg_done_out pulses after me_done_in.
- 55 bytes of 0x00 -> one block: w13=0x00000080, w14=0, w15=0x000001B8, block_last_out=1.
- 56 bytes of 0x00 -> block 1 (block_last_out=0): w14=0x80000000, w15=0. Block 2 (block_last_out=1): w0..w14=0, w15=0x000001C0.
- 64 bytes of 0xFF -> block 1: all words 0xFFFFFFFF, block_last_out=0. Block 2: w0=0x80000000, w15=0x00000200, block_last_out=1.
- me_done_in withheld 100 cycles after a block -> byte_ready_out stays 0 and no second start_out burst occurs. A done pulse injected during S_SEND does not shorten the burst.
- rst_n low at tx_count_out=7 -> all outputs 0 immediately and byte_ready_out=1 after release. A fresh "abc" then yields the block from the first scenario.
